esl_comp_test_sched: RTL

ESL_COMP_TEST_SCHED -- requirements
Module: esl_comp_test_sched

---
 rtl/esl_comp_sched_pkg.sv | 22 ++
 rtl/esl_comp_test_sched_if.sv | 53 +++++
 rtl/esl_fault_filter.sv | 81 ++++++++
 rtl/esl_comp_test_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/esl_comp_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : esl_comp_sched_pkg                                        |
// | Purpose  : Shared types and constants for the complementary-input    |
// |            self-test scheduler.                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package esl_comp_sched_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORCE   = 2'd1,
    ST_RECOVER = 2'd2,
    ST_FAIL    = 2'd3
  } sched_state_e;

  // Cycles from a pair change at the checker inputs to chk_fault reacting.
  localparam int CHK_LATENCY = 3;

endpackage
`default_nettype wire

// File: rtl/esl_comp_test_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : esl_comp_test_sched_if                                    |
// | Purpose  : Signal bundle between the pins/checker side and the       |
// |            self-test scheduler.                                      |
// | Signals  : raw_p/raw_n   pin pairs into the scheduler                |
// |            chk_p/chk_n   pairs to the complementary-input checker    |
// |            chk_fault     checker verdict                             |
// |            clear_req     request to clear latched faults             |
// |            safe_fault, diag_fail, test_busy, test_chan  status       |
// |            test_start    on-demand sweep request, present only when  |
// |                          ESL_COMP_SCHED_ONDEMAND_EN is defined       |
// | Modports : master = environment side, slave = scheduler side         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface esl_comp_test_sched_if #(
  parameter int P_DATA_WIDTH = 7
);
  localparam int CHAN_W = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;

  logic [P_DATA_WIDTH-1:0] raw_p;
  logic [P_DATA_WIDTH-1:0] raw_n;
  logic [P_DATA_WIDTH-1:0] chk_p;
  logic [P_DATA_WIDTH-1:0] chk_n;
  logic                    chk_fault;
  logic                    clear_req;
  logic                    safe_fault;
  logic                    diag_fail;
  logic                    test_busy;
  logic [CHAN_W-1:0]       test_chan;
`ifdef ESL_COMP_SCHED_ONDEMAND_EN
  logic                    test_start;

  modport master (
    output raw_p, raw_n, chk_fault, clear_req, test_start,
    input  chk_p, chk_n, safe_fault, diag_fail, test_busy, test_chan
  );
  modport slave (
    input  raw_p, raw_n, chk_fault, clear_req, test_start,
    output chk_p, chk_n, safe_fault, diag_fail, test_busy, test_chan
  );
`else
  modport master (
    output raw_p, raw_n, chk_fault, clear_req,
    input  chk_p, chk_n, safe_fault, diag_fail, test_busy, test_chan
  );
  modport slave (
    input  raw_p, raw_n, chk_fault, clear_req,
    output chk_p, chk_n, safe_fault, diag_fail, test_busy, test_chan
  );
`endif
endinterface
`default_nettype wire

// File: rtl/esl_fault_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : esl_fault_filter                                          |
// | Purpose  : Debounces the checker verdict outside of self-test and    |
// |            holds the safe_fault / diag_fail latches.                 |
// | Ports    : clk, reset (async, active low)                            |
// |            chk_fault  checker verdict                                |
// |            count_en   scheduler idle, filter may count               |
// |            hold       force the filter count to zero                 |
// |            blocked    sweep in progress, clear requests are dropped  |
// |            fail_set   self-test failure event                        |
// |            clear_req  clear request                                  |
// |            safe_fault, diag_fail  latched flags                      |
// |            clear_ok   clear request accepted this cycle              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module esl_fault_filter #(
  parameter int P_FILT = 8
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic chk_fault,
  input  wire logic count_en,
  input  wire logic hold,
  input  wire logic blocked,
  input  wire logic fail_set,
  input  wire logic clear_req,
  output logic      safe_fault,
  output logic      diag_fail,
  output logic      clear_ok
);
  localparam int              CNT_W   = $clog2(P_FILT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_FILT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             safe_q, safe_d;
  logic             diag_q, diag_d;
  logic             filt_set;

  always_comb begin
    cnt_d    = cnt_q;
    safe_d   = safe_q;
    diag_d   = diag_q;
    if (hold || !chk_fault) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    filt_set = (cnt_d == CNT_MAX);
    // A clear is only honoured once the input is quiet and no sweep runs;
    // anything else drops it so a stale request cannot fire later.
    clear_ok = clear_req && (cnt_q == '0) && !blocked;
    // Set has priority over clear.
    if (filt_set || fail_set) begin
      safe_d = 1'b1;
    end else if (clear_ok) begin
      safe_d = 1'b0;
    end
    if (fail_set) begin
      diag_d = 1'b1;
    end else if (clear_ok) begin
      diag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      safe_q <= 1'b0;
      diag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      safe_q <= safe_d;
      diag_q <= diag_d;
    end
  end

  assign safe_fault = safe_q;
  assign diag_fail  = diag_q;
endmodule
`default_nettype wire

// File: rtl/esl_comp_test_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : esl_comp_test_sched                                       |
// | Purpose  : Periodically forces each complementary pair to 0/0 in     |
// |            turn and checks that the downstream checker flags and     |
// |            then releases the fault; filters real input faults.      |
// | Ports    : clk, reset (async, active low)                            |
// |            bus (slave) raw_p/raw_n in, chk_p/chk_n out, chk_fault,   |
// |            clear_req in; safe_fault, diag_fail, test_busy,           |
// |            test_chan out                                             |
// | Options  : ESL_COMP_SCHED_ONDEMAND_EN adds bus.test_start, a pulse   |
// |            that starts a sweep from IDLE                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module esl_comp_test_sched #(
  parameter int P_DATA_WIDTH = 7,
  parameter int P_PERIOD     = 1000,
  parameter int P_SETTLE     = 6,
  parameter int P_FILT       = 8
) (
  input wire logic             clk,
  input wire logic             reset,
  esl_comp_test_sched_if.slave bus
);
  import esl_comp_sched_pkg::*;

  localparam int CHAN_W = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
  localparam int PER_W  = $clog2(P_PERIOD);
  localparam int SET_W  = $clog2(P_SETTLE);
  localparam int FL_W   = $clog2(CHK_LATENCY + 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(P_PERIOD - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(P_SETTLE - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(P_DATA_WIDTH - 1);

  sched_state_e            state_q, state_d;
  logic [CHAN_W-1:0]       chan_q, chan_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic [SET_W-1:0]        settle_q, settle_d;
  logic [FL_W-1:0]         flush_q, flush_d;
  logic                    pending_q, pending_d;
  logic [P_DATA_WIDTH-1:0] chk_p_q, chk_p_d, chk_n_q, chk_n_d;
  logic [P_DATA_WIDTH-1:0] force_mask;
  logic                    in_sweep, is_idle, od_start, clear_ok;
  logic                    fail_set, filt_hold, safe_fault, diag_fail;

`ifdef ESL_COMP_SCHED_ONDEMAND_EN
  assign od_start = bus.test_start;
`else
  assign od_start = 1'b0;
`endif

  assign in_sweep = (state_q == ST_FORCE) || (state_q == ST_RECOVER);
  assign is_idle  = (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    settle_d  = settle_q;
    pending_d = pending_q;
    // The period counter free-runs so sweep starts keep a fixed cadence.
    period_d  = (period_q == PER_LAST) ? '0 : period_q + 1'b1;
    flush_d   = (flush_q != '0) ? flush_q - 1'b1 : flush_q;
    unique case (state_q)
      ST_IDLE: begin
        if (od_start || pending_q || (period_q == PER_LAST)) begin
          state_d   = ST_FORCE;
          chan_d    = '0;
          settle_d  = '0;
          pending_d = 1'b0;
          if (od_start) begin
            period_d = '0;
          end
        end
      end
      ST_FORCE: begin
        settle_d = settle_q + 1'b1;
        if (bus.chk_fault) begin
          state_d  = ST_RECOVER;
          settle_d = '0;
        end else if (settle_q == SET_LAST) begin
          state_d = ST_FAIL;
        end
      end
      ST_RECOVER: begin
        settle_d = settle_q + 1'b1;
        if (!bus.chk_fault) begin
          settle_d = '0;
          if (chan_q == CHAN_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FORCE;
            chan_d  = chan_q + 1'b1;
          end
        end else if (settle_q == SET_LAST) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        pending_d = 1'b0;
        if (clear_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A period boundary during a sweep leaves a single pending start.
    if (in_sweep && (period_q == PER_LAST)) begin
      pending_d = 1'b1;
    end
    // Checker output still reflects forced pairs for a few cycles.
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
      flush_d = FL_W'(CHK_LATENCY);
    end
  end

  // Forcing follows the next state so the pair changes on the same edge
  // the FSM enters FORCE, keeping the checker round trip minimal.
  for (genvar i = 0; i < P_DATA_WIDTH; i++) begin : g_force
    assign force_mask[i] = (state_d == ST_FORCE) && (chan_d == CHAN_W'(i));
  end

  assign chk_p_d = bus.raw_p & ~force_mask;
  assign chk_n_d = bus.raw_n & ~force_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      chan_q    <= '0;
      period_q  <= '0;
      settle_q  <= '0;
      flush_q   <= '0;
      pending_q <= 1'b0;
      chk_p_q   <= '0;
      chk_n_q   <= '1;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      period_q  <= period_d;
      settle_q  <= settle_d;
      flush_q   <= flush_d;
      pending_q <= pending_d;
      chk_p_q   <= chk_p_d;
      chk_n_q   <= chk_n_d;
    end
  end

  assign fail_set  = in_sweep && (state_d == ST_FAIL);
  assign filt_hold = in_sweep || (flush_q != '0);

  esl_fault_filter #(
    .P_FILT(P_FILT)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .chk_fault  (bus.chk_fault),
    .count_en   (is_idle),
    .hold       (filt_hold),
    .blocked    (in_sweep),
    .fail_set   (fail_set),
    .clear_req  (bus.clear_req),
    .safe_fault (safe_fault),
    .diag_fail  (diag_fail),
    .clear_ok   (clear_ok)
  );

  assign bus.chk_p      = chk_p_q;
  assign bus.chk_n      = chk_n_q;
  assign bus.safe_fault = safe_fault;
  assign bus.diag_fail  = diag_fail;
  assign bus.test_busy  = in_sweep;
  assign bus.test_chan  = chan_q;
endmodule
`default_nettype wire
